decim_chain_ctrl: RTL and testbench
===================================

Name: decim_chain_ctrl

Overview:
Run-control sequencer for the delta-sigma decimation chain (CIC R=16 -> FIR R=2 -> halfband stages, overall decimation 128).
- Soft-resets (flushes) the filter chain on start.
- Gates modulator samples into the chain.
- Discards the start-up transient outputs.
- Forwards settled 50-bit outputs through a one-entry valid/ready output register.
- Drains the pipeline on stop.
- Keeps input/output sample counters and a sticky overflow flag for the capture path.

Parameters:
DATA_WIDTH, 50, width of filter-chain output samples
FLUSH_CYCLES, 4, cycles chain_srst_n is held low after start (>=1)
DRAIN_CYCLES, 128, cycles waited in DRAIN for pipeline flush (>=1)
SETTLE_WIDTH, 8, width of cfg_settle_cnt
CNT_WIDTH, 32, width of sample counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin acquisition pulse, honoured only in IDLE
stop  input  1  end acquisition pulse, honoured only in SETTLE/RUN
cfg_settle_cnt  input  SETTLE_WIDTH  number of chain outputs discarded after flush, sampled on start
mod_valid  input  1  modulator sample strobe
chain_in_valid  output  1  gated input strobe to filter chain
chain_srst_n  output  1  synchronous active-low soft reset to filter chain
filt_valid  input  1  filter-chain output strobe
filt_data  input  DATA_WIDTH  filter-chain output sample, signed
out_valid  output  1  output register holds a sample
out_data  output  DATA_WIDTH  registered output sample
out_ready  input  1  downstream accepts sample when out_valid & out_ready
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on DRAIN->IDLE
overflow  output  1  sticky, sample dropped because output register full
state  output  3  IDLE=0 FLUSH=1 SETTLE=2 RUN=3 DRAIN=4
in_count  output  CNT_WIDTH  samples passed to chain this run
out_count  output  CNT_WIDTH  samples loaded into output register this run

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, chain_srst_n=1, out_valid=0, out_data=0, busy=0, done=0, overflow=0, in_count=0, out_count=0, internal counters=0.
- chain_in_valid is combinational: mod_valid & (state==SETTLE | state==RUN). It is 0 in all other states.
- in_count increments on every cycle where chain_in_valid=1. It saturates at all-ones.
- IDLE: start=1 clears in_count, out_count and overflow, latches cfg_settle_cnt, and moves to FLUSH. stop is ignored. If start and stop are both high, start is taken.
- FLUSH: chain_srst_n=0 for exactly FLUSH_CYCLES cycles (registered output), then -> SETTLE. start and stop are ignored. filt_valid is ignored.
- SETTLE: each filt_valid decrements the settle counter and the sample is discarded (not counted). On the cycle the counter reaches 0 via filt_valid, go to RUN. If the latched settle count is 0, go to RUN on the first SETTLE cycle. stop=1 goes to DRAIN and takes priority over the RUN transition.
- RUN: filt_valid loads the output register. stop=1 goes to DRAIN. A filt_valid in the same cycle as stop is still forwarded.
- DRAIN: filt_valid is still forwarded. After exactly DRAIN_CYCLES cycles -> IDLE, with done=1 for one cycle coincident with state==IDLE.
- Output register (RUN/DRAIN only), latency 1: filt_valid at edge t gives out_valid=1 and out_data=filt_data after edge t. out_count increments on each load.
  - If out_valid & out_ready, or out_valid=0: a new filt_valid loads.
  - If out_valid & out_ready and there is no filt_valid: out_valid clears.
  - If out_valid & ~out_ready & filt_valid: the new sample is dropped, out_data is kept, overflow is set (sticky until the next start), and out_count does not increment.
- A pending out_valid survives the transition to IDLE until accepted.
- start in IDLE while out_valid=1 does not clear out_valid.
- rst_n asserted mid-operation: immediate return to reset values. There is no drain and no done pulse.
- Counters and out_data are pure pass-through. No arithmetic on samples; sign is preserved bit-exact.

Test Plan:
1. cfg_settle_cnt=3, start, mod_valid every cycle, 2048 cycles, then stop. Required: chain_srst_n low exactly 4 cycles; the first 3 filt_valid are dropped; out_count = filt_valid count - 3; in_count=2048; done after 128 DRAIN cycles.
2. cfg_settle_cnt=0, start. Required: RUN is entered on the cycle after the first SETTLE cycle. A filt_valid with filt_data=-5 in RUN gives out_data=-5 (50-bit sign-extended) one cycle later.
3. out_ready=0 in RUN, two filt_valid with data 7 then 9. Required: out_data=7, overflow=1, out_count=1. Then out_ready=1 with a simultaneous filt_valid of 11 gives out_data=11.
4. stop during SETTLE (after 1 of 5 settle outputs). Required: DRAIN entered next cycle, chain_in_valid=0, no outputs forwarded from SETTLE, done after 128 cycles.
5. Simultaneous start and stop in IDLE. Required: FLUSH entered. start during RUN is ignored. rst_n low mid-RUN gives all outputs at reset values with done never pulsed.

Source files
------------

// File: rtl/decim_chain_ctrl.sv
// Run-control sequencer for the delta-sigma decimation chain: flush, settle, run, drain,
// with a one-entry valid/ready output register and per-run sample counters.
module decim_chain_ctrl #(
  parameter int unsigned DATA_WIDTH   = 50,
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES = 128,
  parameter int unsigned SETTLE_WIDTH = 8,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [SETTLE_WIDTH-1:0] cfg_settle_cnt,
  input  logic                    mod_valid,
  output logic                    chain_in_valid,
  output logic                    chain_srst_n,
  input  logic                    filt_valid,
  input  logic [DATA_WIDTH-1:0]   filt_data,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [2:0]              state,
  output logic [CNT_WIDTH-1:0]    in_count,
  output logic [CNT_WIDTH-1:0]    out_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFlush  = 3'd1,
    StSettle = 3'd2,
    StRun    = 3'd3,
    StDrain  = 3'd4
  } state_e;

  // One down-counter serves both the flush and the drain interval.
  localparam int unsigned TmrMax = (DRAIN_CYCLES > FLUSH_CYCLES) ? DRAIN_CYCLES : FLUSH_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax) + 1;

  state_e                  state_q, state_d;
  logic [TmrW-1:0]         tmr_q, tmr_d;
  logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
  logic                    srst_n_q, srst_n_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0]    out_cnt_q, out_cnt_d;

  logic clear_run;
  logic fwd_en;
  logic can_load;

  // Sequencer next-state.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    settle_d  = settle_q;
    srst_n_d  = 1'b1;
    done_d    = 1'b0;
    clear_run = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFlush;
          tmr_d     = TmrW'(FLUSH_CYCLES - 1);
          settle_d  = cfg_settle_cnt;
          srst_n_d  = 1'b0;
          clear_run = 1'b1;
        end
      end
      StFlush: begin
        if (tmr_q == '0) begin
          state_d = StSettle;
        end else begin
          tmr_d    = tmr_q - TmrW'(1);
          srst_n_d = 1'b0;
        end
      end
      StSettle: begin
        if (stop) begin
          state_d = StDrain;
          tmr_d   = TmrW'(DRAIN_CYCLES - 1);
        end else if (settle_q == '0) begin
          state_d = StRun;
        end else if (filt_valid) begin
          settle_d = settle_q - SETTLE_WIDTH'(1);
          if (settle_q == SETTLE_WIDTH'(1)) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StDrain;
          tmr_d   = TmrW'(DRAIN_CYCLES - 1);
        end
      end
      StDrain: begin
        if (tmr_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign chain_in_valid = mod_valid & ((state_q == StSettle) | (state_q == StRun));
  assign fwd_en         = filt_valid & ((state_q == StRun) | (state_q == StDrain));
  assign can_load       = ~out_valid_q | out_ready;

  // Output register and counters; a full, stalled register drops the new sample.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    ovf_d       = ovf_q;
    in_cnt_d    = in_cnt_q;

    if (clear_run) begin
      out_cnt_d = '0;
      ovf_d     = 1'b0;
    end

    if (fwd_en && can_load) begin
      out_valid_d = 1'b1;
      out_data_d  = filt_data;
      if (out_cnt_q != '1) begin
        out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
      end
    end else if (fwd_en) begin
      ovf_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear_run) begin
      in_cnt_d = '0;
    end else if (chain_in_valid && (in_cnt_q != '1)) begin
      in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      settle_q    <= '0;
      srst_n_q    <= 1'b1;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      settle_q    <= settle_d;
      srst_n_q    <= srst_n_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign chain_srst_n = srst_n_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign state        = state_q;
  assign in_count     = in_cnt_q;
  assign out_count    = out_cnt_q;

endmodule

// File: tb/tb_decim_chain_ctrl.sv
// Directed bench for decim_chain_ctrl: expected output samples go into a scoreboard queue,
// and a monitor compares them on every output handshake.
module tb_decim_chain_ctrl;

  localparam int unsigned DW = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [7:0]    cfg_settle_cnt;
  logic          mod_valid;
  logic          chain_in_valid;
  logic          chain_srst_n;
  logic          filt_valid;
  logic [DW-1:0] filt_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [2:0]    state;
  logic [31:0]   in_count;
  logic [31:0]   out_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  decim_chain_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .cfg_settle_cnt (cfg_settle_cnt),
    .mod_valid      (mod_valid),
    .chain_in_valid (chain_in_valid),
    .chain_srst_n   (chain_srst_n),
    .filt_valid     (filt_valid),
    .filt_data      (filt_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .state          (state),
    .in_count       (in_count),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drain lasts 128 cycles after the stop edge; done coincides with the return to IDLE.
  task automatic do_drain(input string tag);
    repeat (127) tick();
    check({tag, " still DRAIN"}, 64'(state), 64'd4);
    tick();
    check({tag, " IDLE after drain"}, 64'(state), 64'd0);
    check({tag, " done pulse"}, 64'(done), 64'd1);
    tick();
    check({tag, " done cleared"}, 64'(done), 64'd0);
  endtask

  // Monitor: handshake is stable at the falling edge and completes at the next rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: unexpected sample %0h", out_data);
      end else begin
        check("scoreboard data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] neg5;
    int nfv;
    logic done_seen;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_settle_cnt = 8'd0;
    mod_valid = 1'b0; filt_valid = 1'b0; filt_data = '0; out_ready = 1'b1;
    tick(); tick();
    check("reset state", 64'(state), 64'd0);
    check("reset srst_n", 64'(chain_srst_n), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset in_count", 64'(in_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: settle=3, full-length run, stop with a coincident sample.
    cfg_settle_cnt = 8'd3; mod_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t1 flush srst_n low", 64'(chain_srst_n), 64'd0);
      check("t1 flush state", 64'(state), 64'd1);
      tick();
    end
    check("t1 srst_n released", 64'(chain_srst_n), 64'd1);
    check("t1 SETTLE entered", 64'(state), 64'd2);
    nfv = 0;
    for (int i = 0; i < 2048; i++) begin
      filt_valid = ((i % 8) == 7);
      d = 50'(i) * 50'd1000 - 50'd70000;
      filt_data = d;
      stop = (i == 2047);
      if (filt_valid) begin
        nfv++;
        if (nfv > 3) exp_q.push_back(d);
      end
      tick();
      if (i == 22) check("t1 still SETTLE", 64'(state), 64'd2);
      if (i == 23) check("t1 RUN after 3rd sample", 64'(state), 64'd3);
    end
    stop = 1'b0;
    check("t1 DRAIN entered", 64'(state), 64'd4);
    check("t1 chain_in_valid gated", 64'(chain_in_valid), 64'd0);
    check("t1 in_count", 64'(in_count), 64'd2048);
    filt_valid = 1'b1; filt_data = 50'h2_AAAA_5555_1234; exp_q.push_back(filt_data); nfv++;
    tick();
    filt_valid = 1'b0;
    repeat (126) tick();
    check("t1 still DRAIN", 64'(state), 64'd4);
    tick();
    check("t1 IDLE after drain", 64'(state), 64'd0);
    check("t1 done pulse", 64'(done), 64'd1);
    check("t1 out_count", 64'(out_count), 64'(nfv - 3));
    check("t1 in_count held", 64'(in_count), 64'd2048);
    tick();
    check("t1 done cleared", 64'(done), 64'd0);

    // Test 2: settle=0, RUN one cycle after SETTLE, sign preserved.
    cfg_settle_cnt = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t2 SETTLE", 64'(state), 64'd2);
    tick();
    check("t2 RUN", 64'(state), 64'd3);
    neg5 = -50'sd5;
    filt_valid = 1'b1; filt_data = neg5; exp_q.push_back(neg5);
    tick();
    filt_valid = 1'b0;
    check("t2 out_valid", 64'(out_valid), 64'd1);
    check("t2 out_data -5", 64'(out_data), 64'h0003_FFFF_FFFF_FFFB);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    do_drain("t2");

    // Test 4: stop during SETTLE after 1 of 5 settle outputs.
    cfg_settle_cnt = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    filt_valid = 1'b1; filt_data = 50'd123;
    tick();
    filt_valid = 1'b0;
    tick();
    stop = 1'b1; filt_valid = 1'b1; filt_data = 50'd456;
    tick();
    stop = 1'b0; filt_valid = 1'b0;
    check("t4 DRAIN from SETTLE", 64'(state), 64'd4);
    check("t4 chain_in_valid gated", 64'(chain_in_valid), 64'd0);
    check("t4 no output", 64'(out_valid), 64'd0);
    check("t4 in_count", 64'(in_count), 64'd3);
    do_drain("t4");
    check("t4 out_count", 64'(out_count), 64'd0);

    // Test 3 (entered via simultaneous start+stop): overflow on a stalled register.
    cfg_settle_cnt = 8'd0; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t5 start wins over stop", 64'(state), 64'd1);
    repeat (5) tick();
    check("t3 RUN", 64'(state), 64'd3);
    out_ready = 1'b0;
    filt_valid = 1'b1; filt_data = 50'd7; exp_q.push_back(50'd7);
    tick();
    filt_data = 50'd9;
    tick();
    filt_valid = 1'b0;
    check("t3 data kept", 64'(out_data), 64'd7);
    check("t3 overflow", 64'(overflow), 64'd1);
    check("t3 out_count", 64'(out_count), 64'd1);
    out_ready = 1'b1; filt_valid = 1'b1; filt_data = 50'd11; exp_q.push_back(50'd11);
    tick();
    filt_valid = 1'b0;
    check("t3 reload data", 64'(out_data), 64'd11);
    check("t3 out_count after reload", 64'(out_count), 64'd2);
    tick();
    check("t3 out_valid cleared", 64'(out_valid), 64'd0);
    check("t3 overflow sticky", 64'(overflow), 64'd1);

    // Test 5: start ignored in RUN, then asynchronous reset mid-run.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5 start ignored in RUN", 64'(state), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 rst state", 64'(state), 64'd0);
    check("t5 rst srst_n", 64'(chain_srst_n), 64'd1);
    check("t5 rst out_valid", 64'(out_valid), 64'd0);
    check("t5 rst out_data", 64'(out_data), 64'd0);
    check("t5 rst busy", 64'(busy), 64'd0);
    check("t5 rst overflow", 64'(overflow), 64'd0);
    check("t5 rst in_count", 64'(in_count), 64'd0);
    check("t5 rst out_count", 64'(out_count), 64'd0);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      done_seen = done_seen | done;
    end
    check("t5 no done after reset", 64'(done_seen), 64'd0);
    check("t5 idle after reset", 64'(state), 64'd0);

    check("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
